hoops_scheduler: RTL and testbench



---
 rtl/hoops_pkg.sv | 32 +++
 rtl/hoop_lfsr.sv | 20 ++
 rtl/hoops_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_hoops_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hoops_pkg.sv
// Shared types and constants for the hoop scheduler and its LFSR.
package hoops_pkg;

  // Fibonacci LFSR: taps 16,14,13,11 map to state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Opening window relative to hoop top-left (inclusive bounds)
  localparam logic signed [13:0] WIN_X_LO = 14'sd16;
  localparam logic signed [13:0] WIN_X_HI = 14'sd31;
  localparam logic signed [13:0] WIN_Y_LO = 14'sd8;
  localparam logic signed [13:0] WIN_Y_HI = 14'sd39;

  typedef struct packed {
    logic              valid;
    logic              passed;
    logic signed [11:0] x;
    logic [10:0]       y;
  } hoop_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SPAWN = 2'd2
  } hoop_state_e;

  // One shift step: feedback enters at bit 0, state shifts toward the MSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hoop_lfsr.sv
// Free-running 16-bit LFSR; exposes the low byte used for spawn heights.
module hoop_lfsr
  import hoops_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rand_byte
);

  logic [15:0] lfsr_reg;

  // Advance every cycle; reset reloads the nonzero seed
  always_ff @(posedge clk) begin
    if (reset) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= lfsr_step(lfsr_reg);
  end

  assign rand_byte = lfsr_reg[7:0];

endmodule

// File: rtl/hoops_scheduler.sv
// Hoop slot pool: per-frame move/retire/score, periodic spawn, and a
// registered per-pixel select feeding the shared hoop renderer.
module hoops_scheduler
  import hoops_pkg::*;
#(
  parameter int NUM_HOOPS    = 4,
  parameter int HOOP_SIZE    = 48,
  parameter int SCREEN_W     = 640,
  parameter int Y_MIN        = 64,
  parameter int SPAWN_PERIOD = 120,
  parameter int SPEED        = 2,
  parameter int PLAYER_HALF  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic [10:0]          playerX,
  input  logic [10:0]          playerY,
  output logic [10:0]          offsetX,
  output logic [10:0]          offsetY,
  output logic                 InsideRectangle,
  output logic [2:0]           hoopIndex,
  output logic                 scorePulse,
  output logic                 spawnDropped,
  output logic [NUM_HOOPS-1:0] activeMask
);

  localparam int IDX_W = $clog2(NUM_HOOPS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_HOOPS - 1);
  localparam logic [15:0]        CNT_LAST = 16'(SPAWN_PERIOD - 1);
  localparam logic signed [11:0] SPEED_S  = 12'(SPEED);
  localparam logic signed [13:0] HS_S     = 14'(HOOP_SIZE);
  localparam logic signed [13:0] HS_M1    = 14'(HOOP_SIZE - 1);
  localparam logic signed [13:0] PH_S     = 14'(PLAYER_HALF);

  hoop_slot_t  slot_reg [NUM_HOOPS];
  hoop_state_e state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic move_en, spawn_en;
  logic [7:0] rand_byte;

  hoop_lfsr u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .rand_byte (rand_byte)
  );

  // ---------------- frame FSM ----------------

  // State, slot index and frame counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Next state: walk each slot once, then one spawn cycle; disable stalls
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    move_en        = 1'b0;
    spawn_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (startOfFrame && enable) begin
          state_next = ST_MOVE;
          idx_next   = '0;
        end
      end
      ST_MOVE: begin
        if (enable) begin
          move_en = 1'b1;
          if (idx_reg == LAST_IDX) state_next = ST_SPAWN;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      ST_SPAWN: begin
        if (enable) begin
          state_next = ST_IDLE;
          if (frame_cnt_reg == CNT_LAST) begin
            frame_cnt_next = '0;
            spawn_en       = 1'b1;
          end else begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- slot update ----------------

  hoop_slot_t cur_slot, moved_slot, new_slot;
  logic signed [11:0] x_new;
  logic signed [13:0] mx_ext, my_ext, pcx, pcy;
  logic score_hit;
  logic free_found;
  logic [IDX_W-1:0] free_idx;

  assign pcx = {3'b000, playerX} + PH_S;
  assign pcy = {3'b000, playerY} + PH_S;

  // Move the serviced slot left, retire it off-screen, or detect a pass
  always_comb begin
    cur_slot   = slot_reg[idx_reg];
    moved_slot = cur_slot;
    score_hit  = 1'b0;
    x_new      = cur_slot.x - SPEED_S;
    mx_ext     = {{2{x_new[11]}}, x_new};
    my_ext     = {3'b000, cur_slot.y};
    if (cur_slot.valid) begin
      if (mx_ext + HS_S <= 14'sd0) begin
        moved_slot.valid = 1'b0;
      end else begin
        moved_slot.x = x_new;
        if (!cur_slot.passed &&
            pcx >= mx_ext + WIN_X_LO && pcx <= mx_ext + WIN_X_HI &&
            pcy >= my_ext + WIN_Y_LO && pcy <= my_ext + WIN_Y_HI) begin
          moved_slot.passed = 1'b1;
          score_hit         = 1'b1;
        end
      end
    end
  end

  // Lowest-index free slot and the hoop that would be placed there
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_HOOPS - 1; i >= 0; i--) begin
      if (!slot_reg[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    new_slot.valid  = 1'b1;
    new_slot.passed = 1'b0;
    new_slot.x      = 12'(SCREEN_W);
    new_slot.y      = 11'(Y_MIN) + {3'b000, rand_byte};
  end

  // Slot storage: one write per cycle, from either MOVE or SPAWN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOOPS; i++) slot_reg[i] <= '0;
    end else if (move_en) begin
      slot_reg[idx_reg] <= moved_slot;
    end else if (spawn_en && free_found) begin
      slot_reg[free_idx] <= new_slot;
    end
  end

  logic score_reg, drop_reg;
  logic [NUM_HOOPS-1:0] valid_vec, mask_reg;

  // Event pulses, one cycle after the detecting MOVE/SPAWN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      score_reg <= 1'b0;
      drop_reg  <= 1'b0;
      mask_reg  <= '0;
    end else begin
      score_reg <= move_en && score_hit;
      drop_reg  <= spawn_en && !free_found;
      mask_reg  <= valid_vec;
    end
  end

  // ---------------- pixel path ----------------

  logic signed [13:0] px, py, sel_sx, sel_sy;
  logic [NUM_HOOPS-1:0] hit;
  logic any_hit;
  logic [IDX_W-1:0] sel_idx;

  assign px = {3'b000, pixelX};
  assign py = {3'b000, pixelY};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HOOPS; gi++) begin : g_hit
      logic signed [13:0] sx, sy;
      assign sx = {{2{slot_reg[gi].x[11]}}, slot_reg[gi].x};
      assign sy = {3'b000, slot_reg[gi].y};
      assign hit[gi] = slot_reg[gi].valid &&
                       px >= sx && px <= sx + HS_M1 &&
                       py >= sy && py <= sy + HS_M1;
      assign valid_vec[gi] = slot_reg[gi].valid;
    end
  endgenerate

  // Priority select: lowest-index hitting slot owns the pixel
  always_comb begin
    any_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_HOOPS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    sel_sx = {{2{slot_reg[sel_idx].x[11]}}, slot_reg[sel_idx].x};
    sel_sy = {3'b000, slot_reg[sel_idx].y};
  end

  logic [10:0] off_x_reg, off_y_reg;
  logic        inside_reg;
  logic [2:0]  index_reg;

  // Registered renderer feed; all zero when no hoop covers the pixel
  always_ff @(posedge clk) begin
    if (reset || !any_hit) begin
      off_x_reg  <= '0;
      off_y_reg  <= '0;
      inside_reg <= 1'b0;
      index_reg  <= '0;
    end else begin
      off_x_reg  <= 11'(px - sel_sx);
      off_y_reg  <= 11'(py - sel_sy);
      inside_reg <= 1'b1;
      index_reg  <= 3'(sel_idx);
    end
  end

  assign offsetX         = off_x_reg;
  assign offsetY         = off_y_reg;
  assign InsideRectangle = inside_reg;
  assign hoopIndex       = index_reg;
  assign scorePulse      = score_reg;
  assign spawnDropped    = drop_reg;
  assign activeMask      = mask_reg;

endmodule

// File: tb/tb_hoops_scheduler.sv
// Directed bench: long frame sequence on the default configuration plus a
// small two-slot instance with a short spawn period to force dropped spawns.
module tb_hoops_scheduler;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, enable;
  logic [10:0] pixelX, pixelY, playerX, playerY;

  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, scorePulse, spawnDropped;
  logic [2:0]  hoopIndex;
  logic [3:0]  activeMask;

  logic [10:0] offsetX2, offsetY2;
  logic        inside2, score2, dropped2;
  logic [2:0]  index2;
  logic [1:0]  mask2;

  int total = 0;
  int bad   = 0;
  int score_cnt = 0;
  int drop_cnt  = 0;

  logic [15:0] lfsr_m;
  logic [10:0] y_cap, y0, y1;

  always #5 clk = ~clk;

  hoops_scheduler dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .pixelX(pixelX), .pixelY(pixelY), .playerX(playerX), .playerY(playerY),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .hoopIndex(hoopIndex), .scorePulse(scorePulse), .spawnDropped(spawnDropped),
    .activeMask(activeMask)
  );

  hoops_scheduler #(.NUM_HOOPS(2), .SPAWN_PERIOD(3)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .pixelX(pixelX), .pixelY(pixelY), .playerX(playerX), .playerY(playerY),
    .offsetX(offsetX2), .offsetY(offsetY2), .InsideRectangle(inside2),
    .hoopIndex(index2), .scorePulse(score2), .spawnDropped(dropped2),
    .activeMask(mask2)
  );

  // Reference LFSR: taps 16,14,13,11, seed ACE1, held at seed during reset
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (scorePulse) score_cnt++;
    if (dropped2)   drop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a pixel; returns once the registered result is visible
  task automatic probe(input logic [10:0] px, input logic [10:0] py);
    pixelX = px;
    pixelY = py;
    @(posedge clk); #1;
  endtask

  // One frame: pulse, 4 MOVE edges, capture the LFSR the SPAWN cycle will use
  task automatic frame();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    y_cap = 11'd64 + {3'b000, lfsr_m[7:0]};
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b1;
    pixelX = '0; pixelY = '0; playerX = 11'd1500; playerY = 11'd1500;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_inside", InsideRectangle, 0);
    chk("rst_offx", offsetX, 0);
    chk("rst_offy", offsetY, 0);
    chk("rst_index", hoopIndex, 0);
    chk("rst_mask", activeMask, 0);
    chk("rst_score", scorePulse, 0);
    chk("rst_drop", spawnDropped, 0);

    // Two-slot instance spawns every 3 frames: frames 3 and 6 fill, 9 drops
    frames(5);
    chk("d2_mask_f5", mask2, 2'b01);
    frame();
    chk("d2_mask_f6", mask2, 2'b11);
    frames(2);
    chk("d2_nodrop_f8", drop_cnt, 0);
    frame();
    chk("d2_drop_f9", drop_cnt, 1);
    chk("d2_mask_f9", mask2, 2'b11);

    // Main instance: no spawn before frame 120
    frames(110);
    chk("mask_f119", activeMask, 0);
    chk("d2_drops_f119", drop_cnt, 37);
    frame();
    y0 = y_cap;
    chk("mask_f120", activeMask, 4'b0001);
    probe(11'd640, y0);
    chk("spawn_inside", InsideRectangle, 1);
    chk("spawn_offx", offsetX, 0);
    chk("spawn_offy", offsetY, 0);
    chk("spawn_index", hoopIndex, 0);
    probe(11'd687, y0 + 11'd47);
    chk("corner_offx", offsetX, 47);
    chk("corner_offy", offsetY, 47);
    probe(11'd688, y0);
    chk("right_edge_out", InsideRectangle, 0);
    probe(11'd639, y0);
    chk("left_edge_out", InsideRectangle, 0);
    probe(11'd640, y0 - 11'd1);
    chk("top_edge_out", InsideRectangle, 0);

    // Slot 1 spawns at frame 240
    frames(119);
    frame();
    y1 = y_cap;
    chk("mask_f240", activeMask, 4'b0011);

    // Frames up to 389; slot 0 then sits at x=102
    frames(149);
    playerX = 11'd100;
    playerY = y0 + 11'd8;
    chk("no_score_before", score_cnt, 0);
    frame();                                  // frame 390: x'=100 -> pass
    chk("score_f390", score_cnt, 1);
    probe(11'd110, y0 + 11'd30);
    chk("x100_inside", InsideRectangle, 1);
    chk("x100_offx", offsetX, 10);
    chk("x100_offy", offsetY, 30);
    chk("x100_index", hoopIndex, 0);
    probe(11'd148, y0 + 11'd30);
    chk("x148_out", InsideRectangle, 0);

    // Disabled frame: nothing moves
    enable = 1'b0;
    frame();
    enable = 1'b1;
    probe(11'd110, y0 + 11'd30);
    chk("frozen_offx", offsetX, 10);
    chk("mask_f390", activeMask, 4'b0111);

    frames(10);                               // frames 391..400
    chk("score_once", score_cnt, 1);
    playerX = 11'd1500;
    playerY = 11'd1500;

    // Frame 463: slot 0 at x=-46, partially off-screen
    frames(63);
    chk("mask_f463", activeMask, 4'b0111);
    probe(11'd0, y0);
    chk("neg_inside", InsideRectangle, 1);
    chk("neg_offx", offsetX, 46);
    chk("neg_index", hoopIndex, 0);
    probe(11'd1, y0);
    chk("neg_offx_edge", offsetX, 47);
    probe(11'd2, y0);
    chk("neg_out", InsideRectangle, 0);
    frame();                                  // frame 464: x'=-48 -> retire
    chk("mask_f464", activeMask, 4'b0110);
    probe(11'd0, y0);
    chk("retired_out", InsideRectangle, 0);

    // Frame 465 would score slot 1 (x'=190); reset during its MOVE cycle
    playerX = 11'd190;
    playerY = y1 - 11'd8;
    pixelX  = 11'd200;
    pixelY  = y1;
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_score", scorePulse, 0);
    chk("abort_mask", activeMask, 0);
    chk("abort_inside", InsideRectangle, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_late_score", score_cnt, 1);
    probe(11'd200, y1);
    chk("abort_slot_gone", InsideRectangle, 0);
    frame();
    chk("post_reset_mask", activeMask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
